seq_word_serializer: RTL
========================

// Module: seq_word_serializer
// PURPOSE
// Upstream feeder for the serial sequence-detector stages. Accepts parallel words over a
// valid/ready handshake, buffers one word, and shifts it out one bit per clk on ser_out.
// Back-to-back words stream with no idle cycle.
// ser_out drives the detector's serial 'in'. ser_valid and ser_last frame the stream for
// the bench and for downstream gating.
// PARAMETERS
// WIDTH     8  word length in bits; legal range 2..32
// MSB_FIRST 1  1: bit WIDTH-1 is shifted out first; 0: bit 0 is shifted out first
// IDLE_BIT  0  value driven on ser_out whenever ser_valid=0
// PORTS
// clk         in   1      rising-edge clock
// rst_n       in   1      asynchronous active-low reset
// data_in     in   WIDTH  parallel word; sampled when data_valid&data_ready at posedge
// data_valid  in   1      producer has a word on data_in
// data_ready  out  1      holding register empty; equals ~hold_full
// ser_out     out  1      serial bit, registered
// ser_valid   out  1      ser_out carries a payload bit this cycle, registered
// ser_last    out  1      current ser_out bit is the last bit of its word
// busy        out  1      shifter active or holding register full
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE, hold_full=0, bit_cnt=0, ser_valid=0.
//   Also ser_out=IDLE_BIT, ser_last=0, busy=0, data_ready=1.
// - Storage: hold_reg[WIDTH] plus hold_full; shift_reg[WIDTH]; bit_cnt [$clog2(WIDTH)-1:0].
// - Accept: at a posedge with data_valid=1 and data_ready=1, hold_reg<=data_in and
//   hold_full<=1. data_in is ignored at all other edges.
// - FSM IDLE: ser_valid=0. If hold_full at the posedge, shift_reg<=hold_reg,
//   hold_full<=0, bit_cnt<=0, next state SHIFT.
// - FSM SHIFT: ser_valid=1. ser_out is shift_reg[WIDTH-1] when MSB_FIRST=1, else
//   shift_reg[0]. ser_last=(bit_cnt==WIDTH-1).
//   - Each posedge with bit_cnt!=WIDTH-1: shift one place toward the output end and
//     increment bit_cnt.
//   - Posedge with bit_cnt==WIDTH-1 and hold_full=1: reload shift_reg from hold_reg,
//     hold_full<=0, bit_cnt<=0, stay in SHIFT. There is no gap cycle.
//   - Posedge with bit_cnt==WIDTH-1 and hold_full=0: go to IDLE.
// - Latency: word accepted at edge k; first bit is visible after edge k+1; last bit is
//   visible after edge k+WIDTH; ser_valid falls after edge k+WIDTH+1 if no successor.
// - Simultaneous events: hold drains and no new accept can occur at the same edge,
//   because data_ready=0 while hold_full=1. data_ready returns to 1 in the cycle after
//   the drain.
// - Throughput: sustained 1 bit/clk. At most 2 words in flight (shifter + hold).
// - Reset mid-word: the partial word and the held word are discarded. Outputs return to
//   reset values immediately, without waiting for clk.
// - ser_out=IDLE_BIT and ser_last=0 whenever ser_valid=0.
// - busy = (state==SHIFT) | hold_full.
// TESTING
// T1 WIDTH=8, MSB_FIRST=1: accept 8'hBA at edge 1 -> ser_valid high after edge 2;
//    bits 1,0,1,1,1,0,1,0 on edges 2..9; ser_last only with the final 0; IDLE after
//    edge 10.
// T2 Back-to-back: accept 8'hBA then 8'hDD as soon as data_ready returns ->
//    16 contiguous valid bits 10111010_11011101, ser_valid never drops.
// T3 Backpressure: hold data_valid=1 and change data_in while hold_full=1 ->
//    data_ready=0 and the changed data_in values are not captured; only words present
//    at ready&valid edges are serialized.
// T4 MSB_FIRST=0: accept 8'hBA -> bits 0,1,0,1,1,1,0,1.
// T5 Assert rst_n=0 during the 4th bit of a word with a second word held ->
//    ser_valid=0, ser_out=IDLE_BIT, busy=0, data_ready=1 asynchronously. After release,
//    no residual bits are emitted.
// T6 End-to-end: drive ser_out into the 1011101 detector with the stream
//    8'hBA,8'hBA -> detector Q asserts at each completed occurrence of 1011101.

Source files
------------

// File: rtl/seq_word_serializer.sv
// Word-to-bit serializer with a one-word holding register.
// Feeds the serial sequence detector one bit per clock, gap-free.
module seq_word_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;

    // Accept and drain are exclusive: accept needs hold empty.
    if (data_valid && !hold_full_q) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (!at_last) begin
          if (MSB_FIRST) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
          end else begin
            shift_d = {1'b0, shift_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
        end else if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic out_bit;

  assign out_bit    = MSB_FIRST ? shift_q[WIDTH-1]
                                : shift_q[0];
  assign ser_valid  = (state_q == SHIFT);
  assign ser_out    = ser_valid ? out_bit : IDLE_BIT;
  assign ser_last   = ser_valid & at_last;
  assign busy       = ser_valid | hold_full_q;
  assign data_ready = ~hold_full_q;

endmodule
